// File: rtl/afu_req_arbiter.sv
// Two-client arbiter for the CCI read/write request ports.
// Tags mdata with the client ID, routes responses back and tracks completion.
module afu_req_arbiter #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int MAX_OUT     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   c0_rd_req,
    input  logic [ADDR_LMT-1:0]    c0_rd_addr,
    input  logic [MDATA-2:0]       c0_rd_mdata,
    output logic                   c0_rd_gnt,
    input  logic                   c1_rd_req,
    input  logic [ADDR_LMT-1:0]    c1_rd_addr,
    input  logic [MDATA-2:0]       c1_rd_mdata,
    output logic                   c1_rd_gnt,
    input  logic                   c0_wr_req,
    input  logic [ADDR_LMT-1:0]    c0_wr_addr,
    input  logic [MDATA-2:0]       c0_wr_mdata,
    input  logic [CACHE_WIDTH-1:0] c0_wr_data,
    output logic                   c0_wr_gnt,
    input  logic                   c1_wr_req,
    input  logic [ADDR_LMT-1:0]    c1_wr_addr,
    input  logic [MDATA-2:0]       c1_wr_mdata,
    input  logic [CACHE_WIDTH-1:0] c1_wr_data,
    output logic                   c1_wr_gnt,
    output logic                   c0_rd_rsp_valid,
    output logic [MDATA-2:0]       c0_rd_rsp_mdata,
    output logic [CACHE_WIDTH-1:0] c0_rd_rsp_data,
    output logic                   c1_rd_rsp_valid,
    output logic [MDATA-2:0]       c1_rd_rsp_mdata,
    output logic [CACHE_WIDTH-1:0] c1_rd_rsp_data,
    output logic                   c0_wr_rsp0_valid,
    output logic [MDATA-2:0]       c0_wr_rsp0_mdata,
    output logic                   c0_wr_rsp1_valid,
    output logic [MDATA-2:0]       c0_wr_rsp1_mdata,
    output logic                   c1_wr_rsp0_valid,
    output logic [MDATA-2:0]       c1_wr_rsp0_mdata,
    output logic                   c1_wr_rsp1_valid,
    output logic [MDATA-2:0]       c1_wr_rsp1_mdata,
    input  logic                   c0_done,
    input  logic                   c1_done,
    output logic [ADDR_LMT-1:0]    rd_req_addr,
    output logic [MDATA-1:0]       rd_req_mdata,
    output logic                   rd_req_en,
    input  logic                   rd_req_almostfull,
    input  logic                   rd_rsp_valid,
    input  logic [MDATA-1:0]       rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
    output logic [ADDR_LMT-1:0]    wr_req_addr,
    output logic [MDATA-1:0]       wr_req_mdata,
    output logic [CACHE_WIDTH-1:0] wr_req_data,
    output logic                   wr_req_en,
    input  logic                   wr_req_almostfull,
    input  logic                   wr_rsp0_valid,
    input  logic [MDATA-1:0]       wr_rsp0_mdata,
    input  logic                   wr_rsp1_valid,
    input  logic [MDATA-1:0]       wr_rsp1_mdata,
    output logic                   done,
    output logic                   err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_n;
    logic [1:0][CW-1:0] rd_cnt, wr_cnt, rd_cnt_n, wr_cnt_n;
    logic [1:0] rd_elig, wr_elig, rd_gnt, wr_gnt, rd_dec, under;
    logic [1:0][1:0] wr_dec;
    logic rd_ptr, wr_ptr, started, fin_cond;

    logic [MDATA-2:0]       rd_rsp_md_q, wr_rsp0_md_q, wr_rsp1_md_q;
    logic [CACHE_WIDTH-1:0] rd_rsp_data_q;

    // Round-robin pick: ptr breaks the tie only when both are eligible.
    function automatic logic [1:0] arb(input logic [1:0] elig, input logic ptr);
        if (elig == 2'b11)
            arb = ptr ? 2'b10 : 2'b01;
        else
            arb = elig;
    endfunction

    // Net counter update; an underflow clamps at zero and is flagged.
    function automatic logic [CW:0] upd(input logic [CW-1:0] c, input logic inc,
                                        input logic [1:0] dec);
        logic [CW:0] s;
        s = {1'b0, c} + {{CW{1'b0}}, inc};
        if (s < {{(CW-1){1'b0}}, dec})
            upd = {1'b1, {CW{1'b0}}};
        else
            upd = {1'b0, CW'(s - {{(CW-1){1'b0}}, dec})};
    endfunction

    assign started = (state == RUN);
    assign done    = (state == FIN);

    always_comb begin
        rd_elig[0] = started & c0_rd_req & ~rd_req_almostfull & (rd_cnt[0] < MAX_C);
        rd_elig[1] = started & c1_rd_req & ~rd_req_almostfull & (rd_cnt[1] < MAX_C);
        wr_elig[0] = started & c0_wr_req & ~wr_req_almostfull & (wr_cnt[0] < MAX_C);
        wr_elig[1] = started & c1_wr_req & ~wr_req_almostfull & (wr_cnt[1] < MAX_C);
        rd_gnt = arb(rd_elig, rd_ptr);
        wr_gnt = arb(wr_elig, wr_ptr);
    end

    assign c0_rd_gnt = rd_gnt[0];
    assign c1_rd_gnt = rd_gnt[1];
    assign c0_wr_gnt = wr_gnt[0];
    assign c1_wr_gnt = wr_gnt[1];

    always_comb begin
        rd_dec    = 2'b00;
        wr_dec    = '0;
        under     = 2'b00;
        rd_cnt_n  = rd_cnt;
        wr_cnt_n  = wr_cnt;
        for (int n = 0; n < 2; n++) begin
            logic [CW:0] r, w;
            rd_dec[n] = rd_rsp_valid & (rd_rsp_mdata[MDATA-1] == n[0]);
            wr_dec[n] = {1'b0, wr_rsp0_valid & (wr_rsp0_mdata[MDATA-1] == n[0])}
                      + {1'b0, wr_rsp1_valid & (wr_rsp1_mdata[MDATA-1] == n[0])};
            r = upd(rd_cnt[n], rd_gnt[n], {1'b0, rd_dec[n]});
            w = upd(wr_cnt[n], wr_gnt[n], wr_dec[n]);
            rd_cnt_n[n] = r[CW-1:0];
            wr_cnt_n[n] = w[CW-1:0];
            under[n]    = r[CW] | w[CW];
        end
    end

    assign fin_cond = c0_done & c1_done & (rd_cnt == '0) & (wr_cnt == '0)
                    & ~|rd_gnt & ~|wr_gnt;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (fin_cond) state_n = FIN;
            FIN:     state_n = FIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            rd_cnt <= rd_cnt_n;
            wr_cnt <= wr_cnt_n;
            if (|rd_gnt) rd_ptr <= rd_gnt[0];
            if (|wr_gnt) wr_ptr <= wr_gnt[0];
            if (|under) err <= 1'b1;
        end
    end

    // CCI request issue: idle cycles drive all-zero payloads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_req_en    <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_mdata <= '0;
            wr_req_en    <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_mdata <= '0;
            wr_req_data  <= '0;
        end else begin
            rd_req_en    <= |rd_gnt;
            rd_req_addr  <= rd_gnt[1] ? c1_rd_addr : rd_gnt[0] ? c0_rd_addr : '0;
            rd_req_mdata <= rd_gnt[1] ? {1'b1, c1_rd_mdata}
                          : rd_gnt[0] ? {1'b0, c0_rd_mdata} : '0;
            wr_req_en    <= |wr_gnt;
            wr_req_addr  <= wr_gnt[1] ? c1_wr_addr : wr_gnt[0] ? c0_wr_addr : '0;
            wr_req_mdata <= wr_gnt[1] ? {1'b1, c1_wr_mdata}
                          : wr_gnt[0] ? {1'b0, c0_wr_mdata} : '0;
            wr_req_data  <= wr_gnt[1] ? c1_wr_data : wr_gnt[0] ? c0_wr_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c0_rd_rsp_valid  <= 1'b0;
            c1_rd_rsp_valid  <= 1'b0;
            c0_wr_rsp0_valid <= 1'b0;
            c1_wr_rsp0_valid <= 1'b0;
            c0_wr_rsp1_valid <= 1'b0;
            c1_wr_rsp1_valid <= 1'b0;
            rd_rsp_md_q      <= '0;
            rd_rsp_data_q    <= '0;
            wr_rsp0_md_q     <= '0;
            wr_rsp1_md_q     <= '0;
        end else begin
            c0_rd_rsp_valid  <= rd_rsp_valid & ~rd_rsp_mdata[MDATA-1];
            c1_rd_rsp_valid  <= rd_rsp_valid & rd_rsp_mdata[MDATA-1];
            c0_wr_rsp0_valid <= wr_rsp0_valid & ~wr_rsp0_mdata[MDATA-1];
            c1_wr_rsp0_valid <= wr_rsp0_valid & wr_rsp0_mdata[MDATA-1];
            c0_wr_rsp1_valid <= wr_rsp1_valid & ~wr_rsp1_mdata[MDATA-1];
            c1_wr_rsp1_valid <= wr_rsp1_valid & wr_rsp1_mdata[MDATA-1];
            rd_rsp_md_q      <= rd_rsp_mdata[MDATA-2:0];
            rd_rsp_data_q    <= rd_rsp_data;
            wr_rsp0_md_q     <= wr_rsp0_mdata[MDATA-2:0];
            wr_rsp1_md_q     <= wr_rsp1_mdata[MDATA-2:0];
        end
    end

    assign c0_rd_rsp_mdata  = rd_rsp_md_q;
    assign c1_rd_rsp_mdata  = rd_rsp_md_q;
    assign c0_rd_rsp_data   = rd_rsp_data_q;
    assign c1_rd_rsp_data   = rd_rsp_data_q;
    assign c0_wr_rsp0_mdata = wr_rsp0_md_q;
    assign c1_wr_rsp0_mdata = wr_rsp0_md_q;
    assign c0_wr_rsp1_mdata = wr_rsp1_md_q;
    assign c1_wr_rsp1_mdata = wr_rsp1_md_q;

endmodule

// File: doc/afu_req_arbiter.md
# afu_req_arbiter

Two-client arbiter that shares the single CCI read-request and write-request ports between two AFU request engines (for example, two vector fetch engines). It tags each request's mdata with the client ID and routes read and write responses back to the originating client by that tag. It enforces a per-client outstanding-request limit and raises `done` once both clients report completion and every issued request has been answered. It sits between the user engines and the CCI read/write port pair.

## Interface
Parameters:
- `ADDR_LMT`, 20, request address width
- `MDATA`, 14, mdata width on the CCI side; clients own `MDATA-1` bits, and the MSB is the client tag
- `CACHE_WIDTH`, 512, cache-line data width
- `MAX_OUT`, 32, max outstanding requests per client per direction (read, write)

Ports (`cN_` denotes two copies, N = 0, 1):
- `clk`, in, 1: sole clock
- `reset_n`, in, 1: synchronous, active-low reset
- `start`, in, 1: level or pulse; latched, and no grants are issued before it is seen
- `cN_rd_req`, in, 1: read request; addr/mdata held stable until granted
- `cN_rd_addr`, in, `ADDR_LMT`: read address
- `cN_rd_mdata`, in, `MDATA-1`: client read tag
- `cN_rd_gnt`, out, 1: combinational; transfer occurs when `req & gnt`
- `cN_wr_req` / `cN_wr_addr` / `cN_wr_mdata` / `cN_wr_data` / `cN_wr_gnt`: same scheme for writes; data width `CACHE_WIDTH`
- `cN_rd_rsp_valid`, out, 1 / `cN_rd_rsp_mdata`, out, `MDATA-1` / `cN_rd_rsp_data`, out, `CACHE_WIDTH`: routed read response
- `cN_wr_rsp0_valid`, `cN_wr_rsp1_valid`, out, 1 / `cN_wr_rsp0_mdata`, `cN_wr_rsp1_mdata`, out, `MDATA-1`: routed write responses
- `cN_done`, in, 1: client has finished issuing; level, held high
- `rd_req_addr`, `rd_req_mdata`, `rd_req_en`: out, to CCI; `rd_req_almostfull`: in
- `rd_rsp_valid`, `rd_rsp_mdata`, `rd_rsp_data`: in, from CCI
- `wr_req_addr`, `wr_req_mdata`, `wr_req_data`, `wr_req_en`: out; `wr_req_almostfull`: in
- `wr_rsp0_valid`, `wr_rsp0_mdata`, `wr_rsp1_valid`, `wr_rsp1_mdata`: in
- `done`, out, 1: sticky completion flag
- `err`, out, 1: sticky; set by a response arriving for a client whose counter is 0

## Operation
- Read and write arbiters are independent and identical. Each has a round-robin pointer `ptr`, reset to 0.
- Client N is eligible when: `started`, `cN_req` high, the direction's almostfull is low, and `out_cnt[N] < MAX_OUT`.
- Grant rules:
  - One eligible client: it is granted.
  - Both eligible: client `ptr` is granted.
  - After any grant to client k, `ptr` becomes `~k`.
  - At most one grant per direction per cycle.
- Issue: the granted request is registered onto the CCI port next cycle with `mdata = {N, cN_mdata}` and `en` = 1. In every other cycle `en` = 0, and addr, mdata and data are driven to 0.
- Response routing: `mdata[MDATA-1]` selects the client. The valid and the lower `MDATA-1` bits of mdata are forwarded registered (1 cycle), with data passed along. The non-selected client sees valid = 0.
- Write responses: `wr_rsp0` and `wr_rsp1` are routed independently. Both may target the same client in one cycle.
- Counters: `out_cnt` per client per direction, width `$clog2(MAX_OUT+1)`.
  - +1 on grant.
  - −1 per response: 0, 1 or 2 per cycle for writes.
  - A grant and response(s) in the same cycle apply net.
  - A decrement that would go below 0 is suppressed, the counter stays at 0, and `err` is set.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when `c0_done & c1_done` and all four counters are 0 and no grant occurs in that cycle.
  - DONE is held until reset; it issues no grants.
- Reset mid-operation: all state clears; in-flight responses arriving afterwards set `err` (counters are 0).

## Timing
- Reset values: all `en`/`valid`/`done`/`err` outputs are 0; addr, mdata and data outputs are 0. `gnt` is 0 while in reset, because `started` is 0.
- Request latency: 1 cycle from `req & gnt` to CCI `en`.
- Response latency: 1 cycle from CCI valid to `cN_*_valid`.
- `done` is registered and rises 1 cycle after the RUN → DONE condition holds.
- Almostfull is sampled in the grant cycle. A grant already registered is still issued the following cycle.

## Test plan
- Reset, then `start`, with only `c0_rd_req` held for 3 addresses 0x10, 0x11, 0x12 → `rd_req_en` on 3 consecutive cycles, mdata MSB = 0, `out_cnt` reaches 3. Return 3 responses → `c0_rd_rsp_valid` ×3 and `out_cnt` back to 0.
- Both clients request reads continuously → grants alternate 0, 1, 0, 1; CCI mdata MSB toggles each cycle.
- `rd_req_almostfull` = 1 for 4 cycles with both clients requesting → no grants during those cycles; grants resume the cycle it drops.
- `MAX_OUT` = 4, client 1 issues 4 writes with no responses → `c1_wr_gnt` stays 0. Return one response on `wr_rsp0` and one on `wr_rsp1` in the same cycle → counter drops 4 → 2 and grants resume.
- Both clients raise `cN_done` while 2 reads are outstanding → `done` stays 0. After the last response it rises 1 cycle later and stays high.
- Read response with tag 1 while `c1` read counter = 0 → `err` = 1 (sticky) and the counter stays 0. Assert `reset_n` = 0 for 1 cycle → `err`, `done` and all counters clear.
